mips_mc_ctrl: RTL and testbench
===============================

Name: mips_mc_ctrl

Overview:
- Multi-cycle control sequencer for the MIPS datapath.
- Decodes OpCode/Funct and steps through FETCH → DECODE → EXEC → MEM → WB, driving the datapath control lines (RegDst, Branch, MemRead, MemtoReg, ALUSrc, RegWrite, MemWrite, ALUOp, stop, ...).
- Stalls on a memory ready handshake.
- Counts retired instructions.
- Sits between the instruction register and the datapath muxes/register file/memory.

Parameters:
- CNT_W, 32: width of retired-instruction counter.
- MEM_WAIT_MAX, 15: max cycles a memory access may wait for mem_ready before timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- OpCode  in  6  instruction opcode [31:26] from IR
- Funct  in  6  function field [5:0] from IR
- mem_ready  in  1  memory access completes this cycle
- PCWrite  out  1  unconditional PC load
- Branch  out  1  conditional PC load (PC loads if ALU zero)
- IorD  out  1  memory address mux: 0=PC, 1=ALUOut
- IRWrite  out  1  instruction register load
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- MemtoReg  out  1  write-data mux: 1=MDR
- RegDst  out  1  dest reg mux: 1=rd, 0=rt
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  0=PC, 1=rs
- ALUSrc  out  2  ALU B: 00=rt, 01=4, 10=sign-ext imm, 11=imm<<2
- PCSource  out  2  00=ALU, 01=ALUOut, 10=jump target
- ALUOp  out  4  ALU operation code (package enum)
- stop  out  1  core halted; PC adder frozen
- mem_timeout  out  1  sticky; memory wait exceeded
- instr_cnt  out  CNT_W  retired instruction count

Behaviour:
- State register resets asynchronously to RESET; all outputs 0 while in RESET; instr_cnt=0; mem_timeout=0.
- RESET → FETCH unconditionally on the first clk after rst falls.
- Outputs are Moore (decoded from state) except IRWrite, PCWrite in FETCH and the MEM_RD→MEM_WB advance, which are qualified by mem_ready.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrc=01, ALUOp=ADD, PCSource=00. When mem_ready: IRWrite=1, PCWrite=1, go to DECODE. Otherwise hold.
- DECODE: ALUSrcA=0, ALUSrc=11, ALUOp=ADD (branch target precompute). Next state by OpCode:
  - 0x00 → R_EXEC
  - 0x23/0x2B → MEM_ADDR
  - 0x04 → BRANCH
  - 0x02 → JUMP
  - 0x08/0x0C/0x0D/0x0A → I_EXEC
  - 0x3F → HALT
  - other → illegal handling (see Optional Feature)
- R_EXEC: ALUSrcA=1, ALUSrc=00, ALUOp=FUNCT. Next R_WB.
- R_WB: RegDst=1, RegWrite=1, MemtoReg=0. Next FETCH (retire).
- MEM_ADDR: ALUSrcA=1, ALUSrc=10, ALUOp=ADD. Next MEM_RD if lw, MEM_WR if sw.
- MEM_RD: MemRead=1, IorD=1. When mem_ready → MEM_WB.
- MEM_WB: RegDst=0, MemtoReg=1, RegWrite=1. Next FETCH (retire).
- MEM_WR: MemWrite=1, IorD=1. When mem_ready → FETCH (retire).
- BRANCH: ALUSrcA=1, ALUSrc=00, ALUOp=SUB, Branch=1, PCSource=01. Next FETCH (retire).
- JUMP: PCWrite=1, PCSource=10. Next FETCH (retire).
- I_EXEC: ALUSrcA=1, ALUSrc=10, ALUOp from opcode:
  - addi → ADD
  - andi → AND
  - ori → OR
  - slti → SLT
  - Next I_WB.
- I_WB: RegDst=0, RegWrite=1. Next FETCH (retire).
- HALT: stop=1, all other controls 0; absorbing until rst.
- Retire: instr_cnt increments by 1 on each retire transition; wraps modulo 2^CNT_W; HALT does not retire.
- Wait counter: cleared on entry to FETCH, MEM_RD or MEM_WR; increments each cycle mem_ready=0 in those states.
  - When it reaches MEM_WAIT_MAX with mem_ready still 0: set mem_timeout, go to HALT.
  - mem_ready=1 on the same cycle as the limit wins (access completes, no timeout).
- Latency with mem_ready tied 1:
  - R/I-type, sw: 4 cycles
  - lw: 5 cycles
  - beq, j: 3 cycles
- Reset mid-instruction: immediate return to RESET; counter and mem_timeout cleared.

Optional Feature:
- Macro MIPS_ILLEGAL_TRAP_EN.
- Defined: adds output illegal_op (1 bit, sticky, reset 0). An undefined opcode in DECODE sets illegal_op and goes to HALT.
- Undefined: undefined opcode goes DECODE → FETCH as a NOP and retires (instr_cnt+1); no illegal_op port.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state enum (RESET…HALT)
  - opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_HALT)
  - ALUOp enum (ADD=0, SUB=1, AND=2, OR=3, SLT=4, FUNCT=15)
  - ALUSrc/PCSource encodings
- One natural sub-module: mips_mem_wait_timer (wait counter plus timeout compare).

Test Plan:
- rst=1 then release, mem_ready=1, OpCode=0x00 → RESET → FETCH → DECODE → R_EXEC → R_WB; RegWrite=1 and RegDst=1 only in R_WB; instr_cnt=1 after 5 cycles.
- lw (0x23), mem_ready low 3 cycles in MEM_RD → MemRead and IorD held 3 extra cycles; MemtoReg=1 and RegWrite=1 in MEM_WB; total 8 cycles FETCH-to-FETCH.
- beq (0x04) → Branch=1, ALUOp=SUB, PCSource=01 in state 3; j (0x02) → PCWrite=1, PCSource=10; both retire in 3 cycles.
- mem_ready held 0 in FETCH, MEM_WAIT_MAX=15 → mem_timeout=1 and stop=1 on the 16th wait cycle; mem_ready=1 exactly at cycle 15 → no timeout.
- OpCode=0x3F → stop=1 persists; instr_cnt unchanged; rst asserted during MEM_WR → all outputs 0 immediately (async), instr_cnt=0.
- OpCode=0x11 with MIPS_ILLEGAL_TRAP_EN → illegal_op=1, HALT; without it → returns to FETCH, instr_cnt+1.

Source files
------------

// File: rtl/mips_mc_ctrl_pkg.sv
// rtl/mips_mc_ctrl_pkg.sv - shared types and encodings for the multi-cycle MIPS control sequencer
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    RESET, FETCH, DECODE, R_EXEC, R_WB, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR,
    BRANCH, JUMP, I_EXEC, I_WB, HALT
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_SLT   = 4'd4,
    ALU_FUNCT = 4'd15
  } aluop_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [1:0] ALUB_RT     = 2'b00;
  localparam logic [1:0] ALUB_FOUR   = 2'b01;
  localparam logic [1:0] ALUB_IMM    = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  function automatic aluop_t imm_aluop(input logic [5:0] op);
    case (op)
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      OP_SLTI: return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// rtl/mips_mc_ctrl_if.sv - control bus between the sequencer (master) and the datapath (slave)
// MIPS_ILLEGAL_TRAP_EN adds the sticky illegal_op flag.
interface mips_mc_ctrl_if
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
);
  logic [5:0]       OpCode;
  logic [5:0]       Funct;
  logic             mem_ready;
  logic             PCWrite;
  logic             Branch;
  logic             IorD;
  logic             IRWrite;
  logic             MemRead;
  logic             MemWrite;
  logic             MemtoReg;
  logic             RegDst;
  logic             RegWrite;
  logic             ALUSrcA;
  logic [1:0]       ALUSrc;
  logic [1:0]       PCSource;
  aluop_t           ALUOp;
  logic             stop;
  logic             mem_timeout;
  logic [CNT_W-1:0] instr_cnt;
`ifdef MIPS_ILLEGAL_TRAP_EN
  logic             illegal_op;

  modport master (
    input  OpCode, Funct, mem_ready,
    output PCWrite, Branch, IorD, IRWrite, MemRead, MemWrite, MemtoReg, RegDst,
           RegWrite, ALUSrcA, ALUSrc, PCSource, ALUOp, stop, mem_timeout,
           instr_cnt, illegal_op
  );
  modport slave (
    output OpCode, Funct, mem_ready,
    input  PCWrite, Branch, IorD, IRWrite, MemRead, MemWrite, MemtoReg, RegDst,
           RegWrite, ALUSrcA, ALUSrc, PCSource, ALUOp, stop, mem_timeout,
           instr_cnt, illegal_op
  );
`else
  modport master (
    input  OpCode, Funct, mem_ready,
    output PCWrite, Branch, IorD, IRWrite, MemRead, MemWrite, MemtoReg, RegDst,
           RegWrite, ALUSrcA, ALUSrc, PCSource, ALUOp, stop, mem_timeout,
           instr_cnt
  );
  modport slave (
    output OpCode, Funct, mem_ready,
    input  PCWrite, Branch, IorD, IRWrite, MemRead, MemWrite, MemtoReg, RegDst,
           RegWrite, ALUSrcA, ALUSrc, PCSource, ALUOp, stop, mem_timeout,
           instr_cnt
  );
`endif
endinterface

// File: rtl/mips_mem_wait_timer.sv
// rtl/mips_mem_wait_timer.sv - counts stalled cycles of a memory access and flags the timeout cycle
module mips_mem_wait_timer #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic mem_ready,
  output logic expire
);
  localparam int W = $clog2(MEM_WAIT_MAX + 1);

  logic [W-1:0] cnt;

  // Leaving a wait state always clears, so every access starts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (active && !mem_ready) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

  // Fires on the stalled cycle that brings the count to the limit; ready on that cycle wins.
  assign expire = active && !mem_ready && (cnt == W'(MEM_WAIT_MAX - 1));
endmodule

// File: rtl/mips_mc_ctrl.sv
// rtl/mips_mc_ctrl.sv - multi-cycle MIPS control sequencer with memory stall, timeout and retire count
// MIPS_ILLEGAL_TRAP_EN: undefined opcodes trap to HALT and set illegal_op instead of retiring as NOPs.
module mips_mc_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int MEM_WAIT_MAX = 15
) (
  input logic            clk,
  input logic            rst,
  mips_mc_ctrl_if.master bus
);
  state_t           state, next_state;
  logic             mem_wait, expire, retire;
  logic [CNT_W-1:0] instr_cnt;
  logic             mem_timeout;
  logic             unused_funct;

  assign unused_funct = ^bus.Funct;
  assign mem_wait     = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);

  mips_mem_wait_timer #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) u_wait (
    .clk       (clk),
    .rst       (rst),
    .active    (mem_wait),
    .mem_ready (bus.mem_ready),
    .expire    (expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RESET;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      RESET:    next_state = FETCH;
      FETCH:    if (bus.mem_ready) next_state = DECODE;
                else if (expire)   next_state = HALT;
      DECODE: begin
        case (bus.OpCode)
          OP_RTYPE:                         next_state = R_EXEC;
          OP_LW, OP_SW:                     next_state = MEM_ADDR;
          OP_BEQ:                           next_state = BRANCH;
          OP_J:                             next_state = JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: next_state = I_EXEC;
          OP_HALT:                          next_state = HALT;
`ifdef MIPS_ILLEGAL_TRAP_EN
          default:                          next_state = HALT;
`else
          default:                          next_state = FETCH;
`endif
        endcase
      end
      R_EXEC:   next_state = R_WB;
      R_WB:     next_state = FETCH;
      MEM_ADDR: next_state = (bus.OpCode == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD:   if (bus.mem_ready) next_state = MEM_WB;
                else if (expire)   next_state = HALT;
      MEM_WB:   next_state = FETCH;
      MEM_WR:   if (bus.mem_ready) next_state = FETCH;
                else if (expire)   next_state = HALT;
      BRANCH:   next_state = FETCH;
      JUMP:     next_state = FETCH;
      I_EXEC:   next_state = I_WB;
      I_WB:     next_state = FETCH;
      HALT:     next_state = HALT;
      default:  next_state = RESET;
    endcase
  end

  always_comb begin
    bus.PCWrite  = 1'b0;
    bus.Branch   = 1'b0;
    bus.IorD     = 1'b0;
    bus.IRWrite  = 1'b0;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.MemtoReg = 1'b0;
    bus.RegDst   = 1'b0;
    bus.RegWrite = 1'b0;
    bus.ALUSrcA  = 1'b0;
    bus.ALUSrc   = ALUB_RT;
    bus.PCSource = PCS_ALU;
    bus.ALUOp    = ALU_ADD;
    bus.stop     = 1'b0;
    case (state)
      FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrc  = ALUB_FOUR;
        bus.IRWrite = bus.mem_ready;
        bus.PCWrite = bus.mem_ready;
      end
      DECODE:   bus.ALUSrc = ALUB_IMM_SH;
      R_EXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = ALU_FUNCT;
      end
      R_WB: begin
        bus.RegDst   = 1'b1;
        bus.RegWrite = 1'b1;
      end
      MEM_ADDR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrc  = ALUB_IMM;
      end
      MEM_RD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
      end
      MEM_WB: begin
        bus.MemtoReg = 1'b1;
        bus.RegWrite = 1'b1;
      end
      MEM_WR: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
      end
      BRANCH: begin
        bus.ALUSrcA  = 1'b1;
        bus.ALUOp    = ALU_SUB;
        bus.Branch   = 1'b1;
        bus.PCSource = PCS_ALUOUT;
      end
      JUMP: begin
        bus.PCWrite  = 1'b1;
        bus.PCSource = PCS_JUMP;
      end
      I_EXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrc  = ALUB_IMM;
        bus.ALUOp   = imm_aluop(bus.OpCode);
      end
      I_WB:     bus.RegWrite = 1'b1;
      HALT:     bus.stop = 1'b1;
      default: ;
    endcase
  end

  // Every return to FETCH other than the hold and the post-reset entry completes an instruction.
  assign retire = (next_state == FETCH) && (state != FETCH) && (state != RESET);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_cnt   <= '0;
      mem_timeout <= 1'b0;
    end else begin
      if (retire) instr_cnt   <= instr_cnt + 1'b1;
      if (expire) mem_timeout <= 1'b1;
    end
  end

  assign bus.instr_cnt   = instr_cnt;
  assign bus.mem_timeout = mem_timeout;

`ifdef MIPS_ILLEGAL_TRAP_EN
  logic op_legal, illegal_op;

  assign op_legal = bus.OpCode inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J,
                                       OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_HALT};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            illegal_op <= 1'b0;
    else if (state == DECODE && !op_legal) illegal_op <= 1'b1;
  end

  assign bus.illegal_op = illegal_op;
`endif
endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb/tb_mips_mc_ctrl.sv - directed self-checking bench for mips_mc_ctrl
module tb_mips_mc_ctrl;
  import mips_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   compared   = 0;
  int   mismatched = 0;
  int   n;

  mips_mc_ctrl_if #(.CNT_W(32)) bus ();

  mips_mc_ctrl #(.CNT_W(32), .MEM_WAIT_MAX(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // flags order: PCWrite Branch IorD IRWrite MemRead MemWrite MemtoReg RegDst RegWrite ALUSrcA
  function automatic logic [31:0] cv(input logic [9:0] flags, input logic [1:0] srcb,
                                     input logic [1:0] pcs, input logic [3:0] op, input logic stp);
    return {13'b0, flags, srcb, pcs, op, stp};
  endfunction

  function automatic logic [31:0] ctl();
    return {13'b0, bus.PCWrite, bus.Branch, bus.IorD, bus.IRWrite, bus.MemRead, bus.MemWrite,
            bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA, bus.ALUSrc, bus.PCSource,
            4'(bus.ALUOp), bus.stop};
  endfunction

  localparam logic [31:0] C_RESET      = cv(10'b0000000000, 2'b00, 2'b00, 4'd0,  1'b0);
  localparam logic [31:0] C_FETCH_RDY  = cv(10'b1001100000, 2'b01, 2'b00, 4'd0,  1'b0);
  localparam logic [31:0] C_FETCH_WAIT = cv(10'b0000100000, 2'b01, 2'b00, 4'd0,  1'b0);
  localparam logic [31:0] C_DECODE     = cv(10'b0000000000, 2'b11, 2'b00, 4'd0,  1'b0);
  localparam logic [31:0] C_R_EXEC     = cv(10'b0000000001, 2'b00, 2'b00, 4'd15, 1'b0);
  localparam logic [31:0] C_R_WB       = cv(10'b0000000110, 2'b00, 2'b00, 4'd0,  1'b0);
  localparam logic [31:0] C_MEM_ADDR   = cv(10'b0000000001, 2'b10, 2'b00, 4'd0,  1'b0);
  localparam logic [31:0] C_MEM_RD     = cv(10'b0010100000, 2'b00, 2'b00, 4'd0,  1'b0);
  localparam logic [31:0] C_MEM_WB     = cv(10'b0000001010, 2'b00, 2'b00, 4'd0,  1'b0);
  localparam logic [31:0] C_MEM_WR     = cv(10'b0010010000, 2'b00, 2'b00, 4'd0,  1'b0);
  localparam logic [31:0] C_BRANCH     = cv(10'b0100000001, 2'b00, 2'b01, 4'd1,  1'b0);
  localparam logic [31:0] C_JUMP       = cv(10'b1000000000, 2'b00, 2'b10, 4'd0,  1'b0);
  localparam logic [31:0] C_I_WB       = cv(10'b0000000010, 2'b00, 2'b00, 4'd0,  1'b0);
  localparam logic [31:0] C_HALT       = cv(10'b0000000000, 2'b00, 2'b00, 4'd0,  1'b1);

  logic [5:0] iops [4] = '{6'h08, 6'h0C, 6'h0D, 6'h0A};
  logic [3:0] iexp [4] = '{4'd0, 4'd2, 4'd3, 4'd4};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      $error("%s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  // FETCH is the only state with MemRead high and IorD low.
  task automatic run_to_fetch(output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!(bus.MemRead && !bus.IorD) && cycles < 40);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.mem_ready = 1'b1;
    bus.OpCode = OP_RTYPE;
    bus.Funct = 6'h20;
    #1;
    chk("rst_ctl", ctl(), C_RESET);
    chk("rst_cnt", bus.instr_cnt, 32'd0);
    chk("rst_tmo", 32'(bus.mem_timeout), 32'd0);
`ifdef MIPS_ILLEGAL_TRAP_EN
    chk("rst_ill", 32'(bus.illegal_op), 32'd0);
`endif
    tick();
    rst = 1'b0;
    #1;
    chk("reset_state", ctl(), C_RESET);

    // R-type
    tick(); chk("r_fetch", ctl(), C_FETCH_RDY);
    tick(); chk("r_decode", ctl(), C_DECODE);
    tick(); chk("r_exec", ctl(), C_R_EXEC);
    tick(); chk("r_wb", ctl(), C_R_WB);
    tick(); chk("r_cnt", bus.instr_cnt, 32'd1);
    chk("r_refetch", ctl(), C_FETCH_RDY);

    // lw with three stalled cycles in MEM_RD
    bus.OpCode = OP_LW;
    tick(); chk("lw_decode", ctl(), C_DECODE);
    tick(); chk("lw_addr", ctl(), C_MEM_ADDR);
    tick(); bus.mem_ready = 1'b0; #1; chk("lw_wait0", ctl(), C_MEM_RD);
    tick(); chk("lw_wait1", ctl(), C_MEM_RD);
    tick(); chk("lw_wait2", ctl(), C_MEM_RD);
    bus.mem_ready = 1'b1; #1; chk("lw_done", ctl(), C_MEM_RD);
    tick(); chk("lw_wb", ctl(), C_MEM_WB);
    tick(); chk("lw_refetch", ctl(), C_FETCH_RDY);
    chk("lw_cnt", bus.instr_cnt, 32'd2);

    // beq and j, three cycles each
    bus.OpCode = OP_BEQ;
    tick(); tick(); chk("beq_exec", ctl(), C_BRANCH);
    tick(); chk("beq_refetch", ctl(), C_FETCH_RDY);
    chk("beq_cnt", bus.instr_cnt, 32'd3);
    bus.OpCode = OP_J;
    tick(); tick(); chk("j_exec", ctl(), C_JUMP);
    tick(); chk("j_refetch", ctl(), C_FETCH_RDY);
    chk("j_cnt", bus.instr_cnt, 32'd4);

    // immediate ALU ops
    for (int i = 0; i < 4; i++) begin
      bus.OpCode = iops[i];
      tick(); tick();
      chk($sformatf("i_exec%0d", i), ctl(), cv(10'b0000000001, 2'b10, 2'b00, iexp[i], 1'b0));
      tick(); chk($sformatf("i_wb%0d", i), ctl(), C_I_WB);
      tick(); chk($sformatf("i_refetch%0d", i), ctl(), C_FETCH_RDY);
    end
    chk("i_cnt", bus.instr_cnt, 32'd8);

    // sw latency
    bus.OpCode = OP_SW;
    run_to_fetch(n);
    chk("sw_lat", 32'(n), 32'd4);
    chk("sw_cnt", bus.instr_cnt, 32'd9);

    // ready arriving on the 15th stalled FETCH cycle completes the access
    bus.OpCode = OP_RTYPE;
    bus.mem_ready = 1'b0; #1;
    chk("edge_wait1", ctl(), C_FETCH_WAIT);
    repeat (14) tick();
    chk("edge_wait15", ctl(), C_FETCH_WAIT);
    bus.mem_ready = 1'b1; #1;
    chk("edge_ready", ctl(), C_FETCH_RDY);
    tick(); chk("edge_decode", ctl(), C_DECODE);
    chk("edge_tmo", 32'(bus.mem_timeout), 32'd0);
    tick(); tick(); tick();
    chk("edge_cnt", bus.instr_cnt, 32'd10);

    // undefined opcode
    bus.OpCode = 6'h11;
    tick(); chk("ill_decode", ctl(), C_DECODE);
    tick();
`ifdef MIPS_ILLEGAL_TRAP_EN
    chk("ill_halt", ctl(), C_HALT);
    chk("ill_flag", 32'(bus.illegal_op), 32'd1);
    chk("ill_cnt", bus.instr_cnt, 32'd10);
`else
    chk("ill_nop", ctl(), C_FETCH_RDY);
    chk("ill_cnt", bus.instr_cnt, 32'd11);
`endif

    // async reset in the middle of MEM_WR
    do_reset();
    chk("rst2_cnt", bus.instr_cnt, 32'd0);
    bus.OpCode = OP_RTYPE;
    tick();
    run_to_fetch(n);
    chk("r2_lat", 32'(n), 32'd4);
    chk("r2_cnt", bus.instr_cnt, 32'd1);
    bus.OpCode = OP_SW;
    tick(); tick(); tick();
    bus.mem_ready = 1'b0; #1;
    chk("sw_wr", ctl(), C_MEM_WR);
    rst = 1'b1; #1;
    chk("async_ctl", ctl(), C_RESET);
    chk("async_cnt", bus.instr_cnt, 32'd0);
    tick();
    rst = 1'b0;
    bus.mem_ready = 1'b1;
    #1;

    // HALT is absorbing and does not retire
    bus.OpCode = OP_HALT;
    tick(); tick(); tick();
    chk("halt_ctl", ctl(), C_HALT);
    chk("halt_cnt", bus.instr_cnt, 32'd0);
    repeat (3) tick();
    chk("halt_hold", ctl(), C_HALT);
    chk("halt_cnt_hold", bus.instr_cnt, 32'd0);

    // FETCH stalled past the limit
    do_reset();
    bus.OpCode = OP_RTYPE;
    tick();
    bus.mem_ready = 1'b0; #1;
    repeat (14) tick();
    chk("tmo_wait15", ctl(), C_FETCH_WAIT);
    chk("tmo_not_yet", 32'(bus.mem_timeout), 32'd0);
    tick();
    chk("tmo_halt", ctl(), C_HALT);
    chk("tmo_flag", 32'(bus.mem_timeout), 32'd1);
    chk("tmo_cnt", bus.instr_cnt, 32'd0);
    bus.mem_ready = 1'b1;
    tick();
    chk("tmo_sticky", 32'(bus.mem_timeout), 32'd1);
    do_reset();
    chk("tmo_cleared", 32'(bus.mem_timeout), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
